ss_capture: RTL and testbench
=============================

# ss_capture

Receive-side counterpart of the multiplexed seven-segment driver. Samples the active-low digit-select and segment buses and reconstructs the four BCD digits being displayed. Used as an on-chip loopback monitor and as the capture block for boards that read an external multiplexed display. Tolerates PWM brightness blanking and digit-switch glitches by requiring a stable, non-blank pattern before latching.

## Interface
- STABLE_CYCLES, 16: number of matching non-blank samples needed to latch a digit (legal range 2–255).
- Clk  in  1  system clock (100 MHz).
- Reset  in  1  synchronous, active-high.
- SegmentDrivers  in  4  digit select, active low; bit i low selects digit i.
- SevenSegment  in  8  segments, active low; [6:0] = segments a..g (bit 0 = a), [7] = decimal point (ignored).
- BCD3, BCD2, BCD1, BCD0  out  4 each  last latched value per digit.
- DigitValid  out  4  bit i set when BCDi holds a correctly decoded value.
- DigitError  out  4  bit i set when the last stable pattern on digit i was not a decimal digit.
- FrameDone  out  1  one-cycle pulse when all four digits have been latched since the previous pulse.

## Operation
- Input stage: SegmentDrivers and SevenSegment are registered once (sel_q, seg_q); all logic uses the registered values.
- Select decode: ~sel_q must be one-hot. Zero-hot or multi-hot means no digit is selected. In that case the dwell counter clears, and the latch-done flag clears.
- Blank sample: seg_q[6:0] == 7'h7F. It is skipped. The counter holds and the reference pattern is kept. This makes PWM off-phases transparent.
- Reference pattern: the first non-blank sample after a select change. Any later non-blank sample that differs from it reloads the reference and sets the counter to 1.
- Dwell counter: counts matching non-blank samples and saturates at STABLE_CYCLES. When it reaches STABLE_CYCLES and latch-done is clear:
  - decode the reference;
  - write digit i outputs;
  - set latch-done, giving at most one latch per dwell.
- Decode: the segment patterns for 0–9 map to BCD 0–9. Any other non-blank pattern is an error.
  - Valid: BCDi = value, DigitValid[i] = 1, DigitError[i] = 0.
  - Invalid: BCDi = 4'hF, DigitValid[i] = 0, DigitError[i] = 1.
- Frame tracking, using a 4-bit capture mask:
  - each latch ORs in bit i;
  - when the mask becomes 4'hF, FrameDone pulses on the next cycle and the mask clears in the same cycle;
  - a latch in the pulse cycle goes into the freshly cleared mask.
- State machine:
  - IDLE: no valid select. Go to TRACK on a one-hot select.
  - TRACK: counting. Go to HELD on a latch. Go back to TRACK with the counter reset on a select change to another one-hot value. Go to IDLE on an invalid select.
  - HELD: latched and waiting for a select change. A pattern change in HELD reloads the reference and returns to TRACK, so a digit that updates mid-dwell is recaptured.

## Timing
- Reset values:
  - BCD3..0 = 0, DigitValid = 0, DigitError = 0, FrameDone = 0;
  - counter = 0, mask = 0, state IDLE;
  - sel_q = 4'hF, seg_q = 8'hFF.
- Reset is asserted mid-dwell: everything clears on that edge and the partial dwell is discarded.
- Latency with no blanking: outputs update STABLE_CYCLES+1 cycles after a pattern first appears on the pins.
  - 1 cycle input register;
  - STABLE_CYCLES samples; outputs update on the edge of the last sample.
- With blanking: each blank sample adds one cycle.
- FrameDone: registered, one cycle after the edge on which the fourth latch occurs.
- The driver dwells 2^17 cycles per digit, far above STABLE_CYCLES. Select-switch glitches shorter than STABLE_CYCLES are never latched.

## Structure
- Shared package ss_pkg:
  - SEG_0..SEG_9 7-bit patterns (the same constants the BCD decoder uses);
  - SEG_BLANK = 7'h7F;
  - state enum {IDLE, TRACK, HELD}.
- Sub-module SS_Decoder: combinational. 7-bit active-high segments in, 4-bit BCD plus valid out. It is the inverse of BCD_Decoder, instantiated once on the reference pattern.

## Test plan
- Digit-0 capture: STABLE_CYCLES=16. After Reset, drive SegmentDrivers=4'hE and SevenSegment={1'b1,~SEG_5} constantly. Required: BCD0=5 and DigitValid=4'b0001 exactly 17 cycles after the first drive; no other output changes.
- Short dwell: same pattern held for 12 cycles, then SegmentDrivers=4'hD with 7'h7F. Required: DigitValid stays 0 and FrameDone never pulses.
- PWM blanking: digit 1 selected, SEG_7 and 7'h7F alternated each cycle. Required: BCD1=7 latched after 16 non-blank samples (~32 cycles). A changed pattern (SEG_2) mid-dwell restarts the count from 1.
- Full frame: rotate SegmentDrivers E,D,B,7 at 20 cycles each with SEG_3, SEG_1, SEG_4, SEG_2. Required:
  - BCD0..3 = 3, 1, 4, 2;
  - a single FrameDone pulse one cycle after the digit-3 latch;
  - a second rotation gives exactly one more pulse.
- Bad pattern: digit 2 with segments a-only (7'h7E on the bus). Required: DigitError=4'b0100, DigitValid[2]=0, BCD2=4'hF. A later valid SEG_9 clears the error and sets BCD2=9.
- Reset mid-dwell and multi-hot select:
  - Reset asserted at sample 10 of a dwell: all outputs clear, and capture needs a full 16 new samples.
  - SegmentDrivers=4'hC held: never latches.

Source files
------------

// File: rtl/ss_pkg.sv
// ss_pkg: shared constants and types for the seven-segment capture block.
// Segment patterns are active-high, bit 0 = segment a.
package ss_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  // Raw bus value with every segment off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HELD
  } state_t;

endpackage

// File: rtl/ss_capture_decoder.sv
// SS_Decoder: active-high segment pattern to BCD.
// Non-digit patterns give 4'hF with valid low.
module SS_Decoder
  import ss_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       valid
);

  always_comb begin
    bcd   = 4'hF;
    valid = 1'b1;
    unique case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/ss_capture.sv
// ss_capture: samples a multiplexed active-low seven-segment bus and
// reconstructs the four displayed BCD digits after a stable dwell.
module ss_capture
  import ss_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] SegmentDrivers,
  input  logic [7:0] SevenSegment,
  output logic [3:0] BCD3,
  output logic [3:0] BCD2,
  output logic [3:0] BCD1,
  output logic [3:0] BCD0,
  output logic [3:0] DigitValid,
  output logic [3:0] DigitError,
  output logic       FrameDone
);

  localparam logic [7:0] STABLE = STABLE_CYCLES[7:0];

  logic [3:0]       sel_q;
  logic [7:0]       seg_q;
  logic [3:0]       cur_sel;
  state_t           state;
  logic [7:0]       cnt;
  logic [6:0]       ref_q;
  logic             have_ref;
  logic [3:0]       mask;
  logic [3:0][3:0]  bcd_q;

  logic [3:0]       sel_hot;
  logic             sel_ok;
  logic             blank;
  logic [6:0]       pat;
  logic [1:0]       idx;
  logic             unused_dp;

  state_t           state_n;
  logic [7:0]       cnt_n;
  logic [6:0]       ref_n;
  logic             have_n;
  logic [3:0]       cur_n;
  logic             latch;
  logic [3:0]       latch_bit;

  logic [3:0]       dec_bcd;
  logic             dec_valid;

  assign sel_hot   = ~sel_q;
  assign sel_ok    = (sel_hot != 4'h0) &&
                     ((sel_hot & (sel_hot - 4'h1)) == 4'h0);
  assign blank     = seg_q[6:0] == SEG_BLANK;
  assign pat       = ~seg_q[6:0];
  assign unused_dp = seg_q[7];
  assign latch_bit = latch ? sel_hot : 4'h0;

  always_comb begin
    idx = 2'd0;
    unique case (sel_hot)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  SS_Decoder u_dec (
    .seg   (ref_q),
    .bcd   (dec_bcd),
    .valid (dec_valid)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ref_n   = ref_q;
    have_n  = have_ref;
    cur_n   = cur_sel;
    latch   = 1'b0;
    if (!sel_ok) begin
      state_n = IDLE;
      cnt_n   = 8'd0;
      have_n  = 1'b0;
    end else begin
      if (state == IDLE || sel_q != cur_sel) begin
        cur_n   = sel_q;
        state_n = TRACK;
        cnt_n   = 8'd0;
        have_n  = 1'b0;
      end
      // Blank samples leave count and reference untouched.
      if (!blank) begin
        if (have_n && pat == ref_q) begin
          if (cnt_n != STABLE) cnt_n = cnt_n + 8'd1;
        end else begin
          ref_n   = pat;
          have_n  = 1'b1;
          cnt_n   = 8'd1;
          state_n = TRACK;
        end
        if (cnt_n == STABLE && state_n != HELD) begin
          latch   = 1'b1;
          state_n = HELD;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sel_q      <= 4'hF;
      seg_q      <= 8'hFF;
      cur_sel    <= 4'hF;
      state      <= IDLE;
      cnt        <= 8'd0;
      ref_q      <= 7'h00;
      have_ref   <= 1'b0;
      mask       <= 4'h0;
      bcd_q      <= '0;
      DigitValid <= 4'h0;
      DigitError <= 4'h0;
      FrameDone  <= 1'b0;
    end else begin
      sel_q    <= SegmentDrivers;
      seg_q    <= SevenSegment;
      cur_sel  <= cur_n;
      state    <= state_n;
      cnt      <= cnt_n;
      ref_q    <= ref_n;
      have_ref <= have_n;
      if (latch) begin
        bcd_q[idx]      <= dec_bcd;
        DigitValid[idx] <= dec_valid;
        DigitError[idx] <= !dec_valid;
      end
      // A full mask pulses and restarts with any latch of this cycle.
      if (mask == 4'hF) begin
        FrameDone <= 1'b1;
        mask      <= latch_bit;
      end else begin
        FrameDone <= 1'b0;
        mask      <= mask | latch_bit;
      end
    end
  end

  assign BCD0 = bcd_q[0];
  assign BCD1 = bcd_q[1];
  assign BCD2 = bcd_q[2];
  assign BCD3 = bcd_q[3];

endmodule

// File: tb/tb_ss_capture.sv
// tb_ss_capture: table-driven captures plus hand-written dwell sequences,
// checked through a cycle-stamped scoreboard of expected output snapshots.
module tb_ss_capture;

  logic       Clk;
  logic       Reset;
  logic [3:0] SegmentDrivers;
  logic [7:0] SevenSegment;
  logic [3:0] BCD3, BCD2, BCD1, BCD0;
  logic [3:0] DigitValid, DigitError;
  logic       FrameDone;

  ss_capture #(.STABLE_CYCLES(16)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .SegmentDrivers (SegmentDrivers),
    .SevenSegment   (SevenSegment),
    .BCD3           (BCD3),
    .BCD2           (BCD2),
    .BCD1           (BCD1),
    .BCD0           (BCD0),
    .DigitValid     (DigitValid),
    .DigitError     (DigitError),
    .FrameDone      (FrameDone)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [15:0] bcd;
    logic [3:0]  val;
    logic [3:0]  err;
    string       tag;
  } exp_t;

  typedef struct {
    logic [3:0] sel;
    logic [6:0] seg;
    int         dig;
    logic [3:0] bcd;
    logic       v;
  } vec_t;

  exp_t sbq[$];
  int   fdq[$];
  int   nvec = 0;
  int   nbad = 0;
  int   fd_seen = 0;

  logic [15:0] m_bcd;
  logic [3:0]  m_val, m_err, m_mask;

  always @(negedge Clk) begin : chk
    exp_t e;
    logic fexp;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      nvec++;
      if ({BCD3, BCD2, BCD1, BCD0} !== e.bcd ||
          DigitValid !== e.val || DigitError !== e.err) begin
        nbad++;
        $display("FAIL %s cyc=%0d got bcd=%h val=%b err=%b want bcd=%h val=%b err=%b",
                 e.tag, cyc, {BCD3, BCD2, BCD1, BCD0}, DigitValid, DigitError,
                 e.bcd, e.val, e.err);
      end
    end
    fexp = (fdq.size() > 0 && fdq[0] == cyc);
    if (fexp) void'(fdq.pop_front());
    if (FrameDone === 1'b1) fd_seen++;
    if (fexp || FrameDone !== 1'b0) begin
      nvec++;
      if (FrameDone !== fexp) begin
        nbad++;
        $display("FAIL framedone cyc=%0d got %b want %b", cyc, FrameDone, fexp);
      end
    end
  end

  task automatic drive(input logic [3:0] sel, input logic [6:0] seg_ah);
    SegmentDrivers = sel;
    SevenSegment   = {1'b1, ~seg_ah};
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic model_clear();
    m_bcd  = '0;
    m_val  = '0;
    m_err  = '0;
    m_mask = '0;
  endtask

  task automatic push_snap(input int due, input string tag);
    exp_t e;
    e.due = due;
    e.bcd = m_bcd;
    e.val = m_val;
    e.err = m_err;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  // Stimulus started at cycle c must latch exactly lat cycles later.
  task automatic expect_latch(input int c, input int lat, input int d,
                              input logic [3:0] b, input logic v,
                              input string tag);
    push_snap(c + lat - 1, {tag, "_early"});
    m_bcd[d*4 +: 4] = b;
    m_val[d]        = v;
    m_err[d]        = !v;
    push_snap(c + lat, tag);
    m_mask[d] = 1'b1;
    if (m_mask == 4'hF) begin
      fdq.push_back(c + lat + 1);
      m_mask = 4'h0;
    end
  endtask

  task automatic check_now(input string tag);
    nvec++;
    if ({BCD3, BCD2, BCD1, BCD0} !== m_bcd ||
        DigitValid !== m_val || DigitError !== m_err) begin
      nbad++;
      $display("FAIL %s cyc=%0d got bcd=%h val=%b err=%b want bcd=%h val=%b err=%b",
               tag, cyc, {BCD3, BCD2, BCD1, BCD0}, DigitValid, DigitError,
               m_bcd, m_val, m_err);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    wait_cyc(1);
    Reset = 1'b0;
    sbq.delete();
    fdq.delete();
    model_clear();
  endtask

  task automatic gap();
    drive(4'hF, 7'h00);
    wait_cyc(2);
  endtask

  vec_t tbl[12];
  int   c, fd0;
  logic [3:0] rsel[4];
  logic [6:0] rseg[4];
  logic [3:0] rbcd[4];

  initial begin
    tbl[0]  = '{4'hE, 7'h3F, 0, 4'd0, 1'b1};
    tbl[1]  = '{4'hD, 7'h06, 1, 4'd1, 1'b1};
    tbl[2]  = '{4'hB, 7'h5B, 2, 4'd2, 1'b1};
    tbl[3]  = '{4'h7, 7'h4F, 3, 4'd3, 1'b1};
    tbl[4]  = '{4'hE, 7'h66, 0, 4'd4, 1'b1};
    tbl[5]  = '{4'hD, 7'h6D, 1, 4'd5, 1'b1};
    tbl[6]  = '{4'hB, 7'h7D, 2, 4'd6, 1'b1};
    tbl[7]  = '{4'h7, 7'h07, 3, 4'd7, 1'b1};
    tbl[8]  = '{4'hE, 7'h7F, 0, 4'd8, 1'b1};
    tbl[9]  = '{4'hD, 7'h6F, 1, 4'd9, 1'b1};
    tbl[10] = '{4'hB, 7'h01, 2, 4'hF, 1'b0};
    tbl[11] = '{4'h7, 7'h77, 3, 4'hF, 1'b0};

    model_clear();
    Reset = 1'b1;
    drive(4'hF, 7'h00);
    wait_cyc(3);
    check_now("reset_state");
    Reset = 1'b0;
    sbq.delete();

    for (int i = 0; i < 12; i++) begin
      gap();
      c = cyc;
      drive(tbl[i].sel, tbl[i].seg);
      expect_latch(c, 17, tbl[i].dig, tbl[i].bcd, tbl[i].v,
                   $sformatf("table%0d", i));
      wait_cyc(20);
    end

    // Digit 0 after reset: exact 17-cycle latency.
    do_reset();
    c = cyc;
    drive(4'hE, 7'h6D);
    expect_latch(c, 17, 0, 4'd5, 1'b1, "dig0");
    wait_cyc(24);
    check_now("dig0_hold");

    // Dwell too short, then a blank digit.
    do_reset();
    drive(4'hE, 7'h6D);
    wait_cyc(12);
    drive(4'hD, 7'h00);
    wait_cyc(30);
    check_now("short_dwell");

    // PWM blanking on digit 1.
    gap();
    c = cyc;
    expect_latch(c, 32, 1, 4'd7, 1'b1, "pwm");
    for (int k = 0; k < 40; k++) begin
      drive(4'hD, (k % 2 == 0) ? 7'h07 : 7'h00);
      wait_cyc(1);
    end

    // Pattern change mid-dwell restarts the count.
    gap();
    c = cyc;
    expect_latch(c, 52, 1, 4'd2, 1'b1, "restart");
    for (int k = 0; k < 60; k++) begin
      if (k % 2 == 1) drive(4'hD, 7'h00);
      else drive(4'hD, (k < 20) ? 7'h07 : 7'h5B);
      wait_cyc(1);
    end

    // Non-digit pattern, then a valid nine on the same dwell.
    gap();
    c = cyc;
    drive(4'hB, 7'h01);
    expect_latch(c, 17, 2, 4'hF, 1'b0, "bad_pat");
    wait_cyc(20);
    c = cyc;
    drive(4'hB, 7'h6F);
    expect_latch(c, 17, 2, 4'd9, 1'b1, "bad_to_nine");
    wait_cyc(20);

    // Reset in the middle of a dwell.
    gap();
    drive(4'hE, 7'h6D);
    wait_cyc(10);
    do_reset();
    check_now("rst_clear");
    c = cyc;
    expect_latch(c, 17, 0, 4'd5, 1'b1, "rst_recap");
    wait_cyc(20);

    // Multi-hot select never latches.
    drive(4'hC, 7'h4F);
    wait_cyc(40);
    check_now("multihot");

    // Two full rotations: one FrameDone each.
    rsel = '{4'hE, 4'hD, 4'hB, 4'h7};
    rseg = '{7'h4F, 7'h06, 7'h66, 7'h5B};
    rbcd = '{4'd3, 4'd1, 4'd4, 4'd2};
    do_reset();
    fd0 = fd_seen;
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 4; d++) begin
        c = cyc;
        drive(rsel[d], rseg[d]);
        expect_latch(c, 17, d, rbcd[d], 1'b1, $sformatf("frame%0d_d%0d", r, d));
        wait_cyc(20);
      end
    end
    gap();
    wait_cyc(3);
    nvec++;
    if (fd_seen - fd0 != 2) begin
      nbad++;
      $display("FAIL frame_pulses got %0d want 2", fd_seen - fd0);
    end
    nvec++;
    if (sbq.size() != 0 || fdq.size() != 0) begin
      nbad++;
      $display("FAIL pending got %0d/%0d want 0/0", sbq.size(), fdq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
